// File: rtl/dtw_pkg.sv
// Shared definitions for the DTW query sequencer: state encoding and timing constants.
package dtw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CLEAR,
        ST_STREAM,
        ST_DRAIN,
        ST_RESULT
    } dtw_state_e;

    localparam int DTW_TIMEOUT_SLACK = 8;
    localparam int DRAIN_CYCLES      = 2;

    // Index width for a table of the given depth; never below one bit.
    function automatic int dtw_idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dtw_sqg_buffer.sv
// Squiggle sample store: one synchronous write port, one asynchronous read port.
module dtw_sqg_buffer
    import dtw_pkg::*;
#(
    parameter int SQG_SIZE = 10,
    parameter int width    = 16,
    parameter int AW       = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [width-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [width-1:0] rdata
);

    localparam int IW = dtw_idx_w(SQG_SIZE);

    logic [width-1:0] mem_q [SQG_SIZE];

    always_ff @(posedge clk) begin
        if (we && (waddr < AW'(SQG_SIZE))) begin
            mem_q[waddr[IW-1:0]] <= wdata;
        end
    end

    // Addresses past the table read as zero so the caller never sees stale entries.
    assign rdata = (raddr < AW'(SQG_SIZE)) ? mem_q[raddr[IW-1:0]] : '0;

endmodule

// File: rtl/dtw_query_sequencer.sv
// Runs one DTW datapath through a full query: load squiggle, clear, stream
// squiggle + reference words, wait for done, hand the result to the host.
module dtw_query_sequencer
    import dtw_pkg::*;
#(
    parameter int width    = 16,
    parameter int SQG_SIZE = 10,
    parameter int REF_SIZE = 1000,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    input  logic              sq_valid,
    input  logic [width-1:0]  sq_data,
    output logic              sq_ready,
    output logic              ref_en,
    output logic [ADDR_W-1:0] ref_addr,
    input  logic [width-1:0]  ref_data,
    output logic              dp_rst,
    output logic              dp_running,
    output logic [width-1:0]  dp_squiggle,
    output logic [width-1:0]  dp_rword,
    input  logic [width-1:0]  dp_minval,
    input  logic [31:0]       dp_position,
    input  logic              dp_done,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [width-1:0]  res_minval,
    output logic [31:0]       res_position,
    output logic              res_timeout
);

    localparam int          CNT_W      = $clog2(SQG_SIZE + 1);
    localparam int          DW         = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] SQ_LAST    = CNT_W'(SQG_SIZE - 1);
    localparam logic [DW-1:0]    DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
    localparam logic [31:0] K_LIMIT    = 32'(REF_SIZE + SQG_SIZE + DTW_TIMEOUT_SLACK);

    dtw_state_e       state_q;
    logic [CNT_W-1:0] sq_cnt_q;
    logic [31:0]      k_q;
    logic [DW-1:0]    drain_q;
    logic             timeout_q;
    logic             step_vld_q;
    logic             step_ref_q;
    logic [width-1:0] rword_q;
    logic [width-1:0] squiggle_q;
    logic [width-1:0] res_minval_q;
    logic [31:0]      res_position_q;
    logic             res_timeout_q;

    logic             buf_we;
    logic [width-1:0] buf_rdata;

    assign buf_we = (state_q == ST_LOAD) && sq_valid;

    dtw_sqg_buffer #(
        .SQG_SIZE (SQG_SIZE),
        .width    (width),
        .AW       (CNT_W)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (sq_cnt_q),
        .wdata (sq_data),
        .raddr (CNT_W'(k_q)),
        .rdata (buf_rdata)
    );

    assign busy       = (state_q != ST_IDLE);
    assign sq_ready   = (state_q == ST_LOAD);
    assign dp_rst     = rst || (state_q == ST_CLEAR);
    assign dp_running = (state_q == ST_STREAM);
    assign ref_en     = (state_q == ST_STREAM) && (k_q < 32'(REF_SIZE));
    assign ref_addr   = ref_en ? ADDR_W'(k_q) : '0;

    // Memory data arrives one cycle after ref_en, exactly when the step's data is due,
    // so it is forwarded straight through and captured for holding afterwards.
    assign dp_rword    = step_vld_q ? (step_ref_q ? ref_data : '0) : rword_q;
    assign dp_squiggle = squiggle_q;

    assign res_valid    = (state_q == ST_RESULT);
    assign res_minval   = res_minval_q;
    assign res_position = res_position_q;
    assign res_timeout  = res_timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            sq_cnt_q       <= '0;
            k_q            <= '0;
            drain_q        <= '0;
            timeout_q      <= 1'b0;
            step_vld_q     <= 1'b0;
            step_ref_q     <= 1'b0;
            rword_q        <= '0;
            squiggle_q     <= '0;
            res_minval_q   <= '0;
            res_position_q <= '0;
            res_timeout_q  <= 1'b0;
        end else begin
            step_vld_q <= (state_q == ST_STREAM);
            step_ref_q <= ref_en;
            if (step_vld_q) begin
                rword_q <= dp_rword;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        sq_cnt_q <= '0;
                        state_q  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (sq_valid) begin
                        if (sq_cnt_q == SQ_LAST) begin
                            sq_cnt_q <= '0;
                            state_q  <= ST_CLEAR;
                        end else begin
                            sq_cnt_q <= sq_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_CLEAR: begin
                    k_q       <= '0;
                    timeout_q <= 1'b0;
                    state_q   <= ST_STREAM;
                end
                ST_STREAM: begin
                    k_q        <= k_q + 32'd1;
                    squiggle_q <= (k_q < 32'(SQG_SIZE)) ? buf_rdata : '0;
                    if (dp_done) begin
                        drain_q <= '0;
                        state_q <= ST_DRAIN;
                    end else if (k_q + 32'd1 == K_LIMIT) begin
                        timeout_q <= 1'b1;
                        drain_q   <= '0;
                        state_q   <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Datapath min/position registers need the full drain window to settle.
                    if (drain_q == DRAIN_LAST) begin
                        res_minval_q   <= dp_minval;
                        res_position_q <= dp_position;
                        res_timeout_q  <= timeout_q;
                        drain_q        <= '0;
                        state_q        <= ST_RESULT;
                    end else begin
                        drain_q <= drain_q + DW'(1);
                    end
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/dtw_query_sequencer.md
# dtw_query_sequencer

Drives one DTW datapath instance through a complete query. Collects `SQG_SIZE` squiggle samples from the host and clears the datapath. Then streams the squiggle and the reference words in the datapath's running/data timing, waits for the datapath's done, and returns the minimum score and position to the host on a valid/ready handshake. It is the initiator of the datapath's input interface and the responder on the host side.

## Interface
- `width`, 16: sample, reference-word and score width.
- `SQG_SIZE`, 10: squiggle samples per query; must match the datapath.
- `REF_SIZE`, 1000: reference words per query; must match the datapath.
- `ADDR_W`, 16: reference memory address width; `2**ADDR_W >= REF_SIZE`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin query; sampled in IDLE only.
- `busy` out 1: high in every state except IDLE.
- `sq_valid` in 1, `sq_data` in `width`, `sq_ready` out 1: squiggle input stream.
- `ref_en` out 1, `ref_addr` out `ADDR_W`: reference memory read request.
- `ref_data` in `width`: read data, valid exactly 1 cycle after `ref_en`.
- `dp_rst` out 1: synchronous clear pulse to the datapath.
- `dp_running` out 1: datapath running strobe.
- `dp_squiggle` out `width`, `dp_rword` out `width`: datapath data inputs.
- `dp_minval` in `width`, `dp_position` in 32, `dp_done` in 1: datapath results.
- `res_valid` out 1, `res_ready` in 1: result handshake.
- `res_minval` out `width`, `res_position` out 32, `res_timeout` out 1: result payload.

## Operation
- **Reset values.** All outputs 0, except `dp_rst`=1 while `rst` is high. State is IDLE and all counters are 0.
- **IDLE.** On `start`=1, go to LOAD. `sq_ready`=0 in IDLE.
- **LOAD.**
  - `sq_ready`=1.
  - Each `sq_valid && sq_ready` writes `sq_data` into local buffer entry `sq_cnt` (0-based), then increments `sq_cnt`.
  - After entry `SQG_SIZE-1` is written, go to CLEAR. `sq_ready` drops in the same cycle.
- **CLEAR.** `dp_rst`=1 for exactly 1 cycle, then go to STREAM.
- **STREAM.**
  - `dp_running`=1 every cycle.
  - Step counter `k` starts at 0 and increments every cycle.
  - For `k < REF_SIZE`: `ref_en`=1 and `ref_addr`=`k`. For `k >= REF_SIZE`: `ref_en`=0.
  - Step `k`'s data is presented 1 cycle after `ref_en`:
    - `dp_rword` = `ref_data`, or 0 for `k >= REF_SIZE`.
    - `dp_squiggle` = buffer[`k`] for `k < SQG_SIZE`, otherwise 0.
  - Exit to DRAIN when `dp_done`=1.
  - Exit to DRAIN with the timeout flag set when `k` reaches `REF_SIZE+SQG_SIZE+8`.
- **DRAIN.** `dp_running`=0. Hold 2 cycles so the datapath min/position registers settle, then capture `dp_minval`, `dp_position` and the timeout flag into the `res_*` registers. Go to RESULT.
- **RESULT.**
  - `res_valid`=1, with the payload held stable, until `res_ready`=1.
  - On the handshake cycle, return to IDLE. A `start` in that same cycle is ignored; it must be reasserted.
- **Ignored inputs.** `start` outside IDLE has no effect. `sq_valid` outside LOAD has no effect.
- **Reset mid-query.** Aborts immediately. No result is produced, and `res_valid` falls asynchronously.
- **Early done.** `dp_done` seen in the first STREAM cycle: DRAIN still takes 2 cycles.

## Timing
- **Running/data alignment.** Let `s` be the first cycle with `dp_running`=1. Data for step `k` appears on cycle `s+1+k`, so data lags `dp_running` by 1 cycle. This matches the datapath, which registers `running` before sampling the data.
- **Data outputs.** `dp_rword` and `dp_squiggle` are registered and hold their value when not updated.
- **CLEAR to STREAM.** The `dp_rst` cycle is immediately followed by cycle `s`.
- **Best-case latency, start to result.**
  - 1 cycle IDLE.
  - `SQG_SIZE` cycles LOAD with `sq_valid` held high.
  - 1 cycle CLEAR.
  - STREAM for the datapath's done latency.
  - 2 cycles DRAIN.
  - `res_valid` asserts the cycle after DRAIN ends.
- **Counters.** `sq_cnt` uses ceil(log2(`SQG_SIZE`+1)) bits. `k` is 32 bits. The result registers are plain captures with no arithmetic.

## Structure
- **Shared package `dtw_pkg`:**
  - state encoding: IDLE, LOAD, CLEAR, STREAM, DRAIN, RESULT;
  - `DTW_TIMEOUT_SLACK`=8;
  - `DRAIN_CYCLES`=2.
- **Sub-module `dtw_sqg_buffer`:** `SQG_SIZE`x`width` register file with one write port and one asynchronous read port.
- **Top level:** FSM, step counter and output registers stay in `dtw_query_sequencer`.

## Test plan
- **Nominal query.**
  - Setup: `SQG_SIZE`=4, `REF_SIZE`=16, squiggle {3,7,1,9}, ref memory word i = i, `dp_done` model asserts 20 cycles after `s`, `dp_minval`=5, `dp_position`=11.
  - Expect: one `dp_rst` pulse, then `dp_running` high from `s`, `dp_rword`=0,1,...,15,0,... starting at `s+1`, and `dp_squiggle`=3,7,1,9,0,... starting at `s+1`.
  - Expect: `res_valid` with minval 5, position 11, timeout 0.
- **Squiggle backpressure.** `sq_valid` toggled 1,0,1,0 during LOAD -> buffer holds exactly the accepted samples in order; CLEAR is entered only after the 4th accept.
- **Timeout.** `dp_done` never asserts -> STREAM exits at `k`=28 (`REF_SIZE+SQG_SIZE+8` with the nominal parameters), and `res_timeout`=1.
- **Result stall.** `res_ready`=0 for 10 cycles -> payload stable, `busy`=1; `start` pulses are ignored. Handshake -> IDLE on the next cycle.
- **Reset mid-STREAM.** Assert `rst` at `k`=5 -> all outputs 0 asynchronously, `dp_rst`=1; after release, a new nominal query completes correctly.
- **Spurious inputs in IDLE.** `sq_valid`=1 and `res_ready`=1 with no `start` -> no state change, `sq_ready`=0.
